// File: rtl/pc_redirect_unit.sv
// Fetch PC register with EX-stage branch/jump redirect, one-cycle squash and misaligned-target halt.
// Latency: redirect/flush combinational in the take cycle; pc loads the target at the next edge.
// Backpressure: stall holds pc unless a redirect is taken (redirect wins); HALT freezes pc until rst.
//
// Ports: clk, rst (async active-high); stall; EX controls ex_valid/ex_branch/ex_jal/ex_jalr/br_out;
//        EX data ex_pc/ex_imm/ex_rs1; outputs pc (registered), ex_link, redirect, flush_if_id,
//        flush_id_ex, misalign_trap (sticky).
// Optional feature macro BR_STATS_EN adds br_count / taken_count branch statistics outputs.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic        br_out,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    output logic [31:0] pc,
    output logic [31:0] ex_link,
    output logic        redirect,
    output logic        flush_if_id,
    output logic        flush_id_ex,
`ifdef BR_STATS_EN
    output logic [31:0] br_count,
    output logic [31:0] taken_count,
`endif
    output logic        misalign_trap
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SQUASH = 2'b01,
        HALT   = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;

    logic        take;
    logic [31:0] target;
    logic        redirect_c;
    logic        flush_c;

    // jalr clears bit 0 of the sum; jal and branches are pc-relative.
    always_comb begin
        if (ex_jalr) begin
            target = (ex_rs1 + ex_imm) & ~32'h1;
        end else begin
            target = ex_pc + ex_imm;
        end
    end

    assign take = ex_valid & (state_q == RUN) & (ex_jalr | ex_jal | (ex_branch & br_out));

    always_comb begin
        state_d    = state_q;
        misalign_d = misalign_q;
        redirect_c = 1'b0;
        flush_c    = 1'b0;
        pc_d       = stall ? pc_q : pc_q + 32'd4;
        case (state_q)
            RUN: begin
                if (take) begin
                    flush_c = 1'b1;
                    if (target[1:0] == 2'b00) begin
                        redirect_c = 1'b1;
                        pc_d       = target;
                        state_d    = SQUASH;
                    end else begin
                        // Faulting transfer: squash the younger work but never fetch the bad target.
                        pc_d       = pc_q;
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end
                end
            end
            SQUASH: begin
                state_d = RUN;
            end
            HALT: begin
                pc_d    = pc_q;
                flush_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef BR_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] taken_count_q, taken_count_d;

    // Only branches seen in RUN count; the squash shadow is not a real instruction.
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (ex_valid && ex_branch && (state_q == RUN)) begin
            br_count_d = br_count_q + 32'd1;
            if (br_out) begin
                taken_count_d = taken_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q    <= 32'd0;
            taken_count_q <= 32'd0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;
`endif

    // Combinational outputs are forced quiet while reset is held.
    assign pc            = pc_q;
    assign ex_link       = rst ? 32'd0 : ex_pc + 32'd4;
    assign redirect      = redirect_c & ~rst;
    assign flush_if_id   = flush_c & ~rst;
    assign flush_id_ex   = flush_c & ~rst;
    assign misalign_trap = misalign_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid, ex_branch, ex_jal, ex_jalr, br_out;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic [31:0] pc, ex_link;
    logic        redirect, flush_if_id, flush_id_ex, misalign_trap;
`ifdef BR_STATS_EN
    logic [31:0] br_count, taken_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_branch    (ex_branch),
        .ex_jal       (ex_jal),
        .ex_jalr      (ex_jalr),
        .br_out       (br_out),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .pc           (pc),
        .ex_link      (ex_link),
        .redirect     (redirect),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
`ifdef BR_STATS_EN
        .br_count     (br_count),
        .taken_count  (taken_count),
`endif
        .misalign_trap(misalign_trap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_branch = 0; ex_jal = 0; ex_jalr = 0; br_out = 0;
        ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
    endtask

    task automatic chk_ctl(input string tag, input logic r, input logic f);
        chk({tag, "_redirect"}, {31'd0, redirect}, {31'd0, r});
        chk({tag, "_flush_if_id"}, {31'd0, flush_if_id}, {31'd0, f});
        chk({tag, "_flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, f});
    endtask

    initial begin
        idle();
        stall = 0;
        rst   = 1;
        ex_valid = 1; ex_jal = 1; ex_pc = 32'h100; ex_imm = 32'h40;
        #12;
        // Reset: registered state and all combinational outputs quiet.
        chk("rst_pc", pc, 32'h0);
        chk("rst_link", ex_link, 32'h0);
        chk_ctl("rst", 1'b0, 1'b0);
        chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
        idle();
        @(negedge clk);
        rst = 0;
        #1;
        chk("seq_pc0", pc, 32'h0);
        step(); chk("seq_pc1", pc, 32'h4);
        step(); chk("seq_pc2", pc, 32'h8);
        step(); chk("seq_pc3", pc, 32'hC);

        // Taken branch with negative offset.
        ex_valid = 1; ex_branch = 1; br_out = 1; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
        #1;
        chk_ctl("br_take", 1'b1, 1'b1);
        chk("br_link", ex_link, 32'h104);
        step(); chk("br_pc", pc, 32'hF0);
        // Squash cycle: same take-looking inputs must be ignored.
        #1;
        chk_ctl("squash", 1'b0, 1'b0);
        step(); chk("squash_pc", pc, 32'hF4);

        // Not-taken branch.
        br_out = 0;
        #1;
        chk_ctl("nt", 1'b0, 1'b0);
        step(); chk("nt_pc", pc, 32'hF8);

        // Plain stall.
        idle(); stall = 1;
        step(); chk("stall_pc", pc, 32'hF8);

        // JAL with wrap-around while stalled: redirect wins.
        ex_valid = 1; ex_jal = 1; ex_pc = 32'hFFFF_FFFC; ex_imm = 32'h8;
        #1;
        chk("jal_link", ex_link, 32'h0);
        chk_ctl("jal", 1'b1, 1'b1);
        step(); chk("jal_pc", pc, 32'h4);
        idle(); stall = 0;
        step(); chk("jal_sq_pc", pc, 32'h8);

        // JALR clears bit 0.
        ex_valid = 1; ex_jalr = 1; ex_rs1 = 32'h201; ex_imm = 32'h0; ex_pc = 32'h40;
        #1;
        chk("jalr_link", ex_link, 32'h44);
        chk_ctl("jalr", 1'b1, 1'b0 | 1'b1);
        step(); chk("jalr_pc", pc, 32'h200);
        idle();
        step(); chk("jalr_sq_pc", pc, 32'h204);

        // Async reset in the middle of SQUASH.
        ex_valid = 1; ex_jal = 1; ex_pc = 32'h0; ex_imm = 32'h80;
        step(); chk("pre_rst_pc", pc, 32'h80);
        idle();
        #2 rst = 1;
        #1 chk("async_rst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 0;

        // Back in RUN immediately: 4 branches (2 taken), squash-cycle branch ignored.
        ex_valid = 1; ex_branch = 1; br_out = 1; ex_pc = 32'h10; ex_imm = 32'h10;
        #1;
        chk("after_rst_redirect", {31'd0, redirect}, 32'd1);
        step(); chk("cnt_pc1", pc, 32'h20);
        step(); chk("cnt_pc2", pc, 32'h24);      // squash, inputs ignored
        br_out = 0;
        step(); chk("cnt_pc3", pc, 32'h28);
        br_out = 1; ex_pc = 32'h30; ex_imm = 32'h20;
        step(); chk("cnt_pc4", pc, 32'h50);
        idle();
        step(); chk("cnt_pc5", pc, 32'h54);
        ex_valid = 1; ex_branch = 1; br_out = 0;
        step(); chk("cnt_pc6", pc, 32'h58);
        idle();
`ifdef BR_STATS_EN
        chk("br_count", br_count, 32'd4);
        chk("taken_count", taken_count, 32'd2);
`endif

        // Misaligned JALR target 0x202 while stalled.
        stall = 1;
        ex_valid = 1; ex_jalr = 1; ex_rs1 = 32'h203; ex_imm = 32'h0; ex_pc = 32'h58;
        #1;
        chk_ctl("mis", 1'b0, 1'b1);
        step();
        chk("halt_pc", pc, 32'h58);
        chk("halt_trap", {31'd0, misalign_trap}, 32'd1);
        chk_ctl("halt", 1'b0, 1'b1);
        // Aligned jump in HALT is ignored; pc frozen even without stall.
        idle(); stall = 0;
        ex_valid = 1; ex_jal = 1; ex_pc = 32'h0; ex_imm = 32'h100;
        #1;
        chk_ctl("halt_jal", 1'b0, 1'b1);
        step(); chk("halt_pc2", pc, 32'h58);
        step(); chk("halt_trap2", {31'd0, misalign_trap}, 32'd1);
        idle();
        rst = 1;
        #1;
        chk("halt_rst_pc", pc, 32'h0);
        chk("halt_rst_trap", {31'd0, misalign_trap}, 32'd0);
        @(negedge clk);
        rst = 0;
        step(); chk("post_halt_pc", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have the following ports (clock and reset first); one clock, reset asynchronous and active-high:
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous active-high reset
  stall  input  1  hazard-unit hold of PC
  ex_valid  input  1  EX-stage instruction valid
  ex_branch  input  1  EX holds conditional branch
  ex_jal  input  1  EX holds JAL
  ex_jalr  input  1  EX holds JALR
  br_out  input  1  branch-condition result from compare unit
  ex_pc  input  32  PC of EX instruction
  ex_imm  input  32  sign-extended immediate
  ex_rs1  input  32  forwarded rs1 value
  pc  output  32  fetch address (registered)
  ex_link  output  32  ex_pc+4, JAL/JALR writeback value
  redirect  output  1  taken control transfer this cycle
  flush_if_id  output  1  squash IF/ID register
  flush_id_ex  output  1  squash ID/EX register
  misalign_trap  output  1  target not word-aligned; sticky

Function
REQ-003 SHALL implement FSM states RUN, SQUASH, HALT.
REQ-004 SHALL define take = ex_valid & (state==RUN) & (ex_jalr | ex_jal | (ex_branch & br_out)).
REQ-005 SHALL compute target with priority jalr > jal > branch: jalr -> (ex_rs1+ex_imm) & ~32'h1; otherwise ex_pc+ex_imm; all sums modulo 2^32 (wrap-around without flag).
REQ-006 SHALL drive ex_link = ex_pc+4 combinationally, modulo 2^32.
REQ-007 SHALL assert redirect, flush_if_id, flush_id_ex combinationally in the same cycle as take when target[1:0]==2'b00.
REQ-008 On take with aligned target, SHALL load pc<=target at the next edge (one-cycle redirect latency) and move RUN->SQUASH.
REQ-009 SHALL ignore all EX inputs in SQUASH (take forced 0), advance pc per REQ-011, and return SQUASH->RUN after exactly one cycle.
REQ-010 On take with target[1:0]!=2'b00, SHALL NOT assert redirect; SHALL assert flush_if_id and flush_id_ex, hold pc, and move to HALT.
REQ-011 With no take in RUN/SQUASH: stall=1 -> pc holds; stall=0 -> pc<=pc+4 (modulo 2^32).
REQ-012 Take and stall in the same cycle: redirect SHALL win; pc loads target.
REQ-013 In HALT SHALL hold pc, keep misalign_trap=1 and flush_if_id=flush_id_ex=1, redirect=0; exit only via rst.
REQ-014 Not-taken conditional branch (br_out=0) SHALL produce no flush and sequential pc.

Reset
REQ-015 rst=1 SHALL asynchronously set pc=RESET_PC, state=RUN, misalign_trap=0, counters=0, regardless of current state or in-flight redirect.
REQ-016 Combinational outputs SHALL read 0 while rst=1.

Configuration
REQ-017 With macro BR_STATS_EN defined, SHALL add outputs br_count[31:0] (increments on every ex_valid & ex_branch in RUN) and taken_count[31:0] (increments on every taken conditional branch), both wrapping at 2^32.
REQ-018 Without BR_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-019 Reset then 3 cycles, stall=0 -> pc = 0x0, 0x4, 0x8, 0xC.
REQ-020 ex_pc=0x100, ex_imm=0xFFFFFFF0, ex_branch=1, br_out=1 -> redirect=1 and both flushes same cycle; pc=0xF0 next edge; ex inputs ignored one cycle.
REQ-021 ex_jalr=1, ex_rs1=0x203, ex_imm=0x0 with stall=1 -> pc=0x202 -> misalign_trap=1, HALT, pc frozen until rst; ex_jalr with ex_rs1=0x201 -> pc=0x200, ex_link=ex_pc+4.
REQ-022 ex_pc=0xFFFFFFFC, ex_imm=0x8, ex_jal=1 -> pc=0x4 (wrap), ex_link=0x0.
REQ-023 rst asserted mid-SQUASH -> pc=RESET_PC immediately, state RUN; with BR_STATS_EN, 4 branches (2 taken) -> br_count=4, taken_count=2.
